// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencer and the pipeline register wrappers.
// Latency: n/a (types only). Backpressure: n/a.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    localparam logic [4:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_bubble;
        logic exmem_en;
        logic memwb_en;
        logic memwb_bubble;
    } pipe_ctl_t;

    function automatic logic load_use_hazard(
        input logic       ex_memread,
        input logic [4:0] ex_rd,
        input logic [4:0] id_rn,
        input logic [4:0] id_rm,
        input logic       id_uses_rm
    );
        return ex_memread && (ex_rd != XZR_IDX) &&
               ((ex_rd == id_rn) || (id_uses_rm && (ex_rd == id_rm)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating event counter, clears on synchronous reset.
// Latency: count reflects inc one cycle later. Backpressure: none, holds at all-ones.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (inc && !(&count)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall/flush sequencer for the 5-stage pipeline with drain-to-halt FSM.
// Latency: controls combinational from state+inputs; FSM/counters registered. Backpressure: memory wait freezes all stages but MEM/WB.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int MAX_WAIT     = 16,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rn,
    input  logic [4:0]       id_rm,
    input  logic             id_uses_rm,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_bubble,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             memwb_bubble,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);

    ctrl_state_t   state_q, state_d;
    logic [DW-1:0] drain_q, drain_d;
    logic [WW-1:0] wait_q,  wait_d;
    logic          timeout_q, timeout_d;
    logic          freeze, lu, stall_inc, flush_inc;
    pipe_ctl_t     ctl;

    assign freeze = (state_q != HALTED) && mem_req && !mem_ready;
    assign lu     = load_use_hazard(ex_memread, ex_rd, id_rn, id_rm, id_uses_rm);

    always_comb begin
        ctl       = '0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        state_d   = state_q;
        drain_d   = drain_q;

        case (state_q)
            RUN: begin
                if (freeze) begin
                    ctl.memwb_en     = 1'b1;
                    ctl.memwb_bubble = 1'b1;
                end else if (ex_br_taken) begin
                    ctl       = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
                                  idex_bubble: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0};
                    flush_inc = 1'b1;
                end else if (lu) begin
                    ctl       = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0, idex_en: 1'b1,
                                  idex_bubble: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0};
                    stall_inc = 1'b1;
                end else begin
                    ctl = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0, idex_en: 1'b1,
                            idex_bubble: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0};
                end
                if (halt_req && !freeze) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                if (freeze) begin
                    ctl.memwb_en     = 1'b1;
                    ctl.memwb_bubble = 1'b1;
                end else begin
                    // Fetch stays blocked; a taken branch still loads PC so resume lands on the target.
                    ctl = '{pc_en: 1'b0, ifid_en: 1'b1, ifid_flush: 1'b1, idex_en: 1'b1,
                            idex_bubble: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_bubble: 1'b0};
                    if (ex_br_taken) begin
                        ctl.pc_en       = 1'b1;
                        ctl.idex_bubble = 1'b1;
                        flush_inc       = 1'b1;
                    end else if (lu) begin
                        ctl.idex_bubble = 1'b1;
                    end
                end
                if (!halt_req) begin
                    state_d = RUN;
                    drain_d = '0;
                end else if (!freeze) begin
                    if (drain_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_d = HALTED;
                        drain_d = '0;
                    end else begin
                        drain_d = drain_q + 1'b1;
                    end
                end
            end
            HALTED: begin
                if (!halt_req) begin
                    state_d = RUN;
                end
            end
            default: state_d = RUN;
        endcase

        if (freeze) begin
            stall_inc = 1'b1;
        end

        if (rst) begin
            ctl       = '0;
            stall_inc = 1'b0;
            flush_inc = 1'b0;
        end
    end

    always_comb begin
        wait_d    = '0;
        timeout_d = timeout_q;
        if (freeze) begin
            wait_d = (wait_q == WW'(MAX_WAIT)) ? wait_q : wait_q + 1'b1;
            if (wait_q >= WW'(MAX_WAIT - 1)) begin
                timeout_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RUN;
            drain_q   <= '0;
            wait_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drain_q   <= drain_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

    assign pc_en        = ctl.pc_en;
    assign ifid_en      = ctl.ifid_en;
    assign ifid_flush   = ctl.ifid_flush;
    assign idex_en      = ctl.idex_en;
    assign idex_bubble  = ctl.idex_bubble;
    assign exmem_en     = ctl.exmem_en;
    assign memwb_en     = ctl.memwb_en;
    assign memwb_bubble = ctl.memwb_bubble;
    assign halted       = (state_q == HALTED) && !rst;
    assign mem_timeout  = timeout_q && !rst;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table, directed corner sequences, random run vs reference model.
module tb_pipeline_hazard_ctrl;

    localparam int DRAIN_CYCLES = 4;
    localparam int MAX_WAIT     = 16;
    localparam int CNT_W        = 6;
    localparam int MAXC         = (1 << CNT_W) - 1;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble}
    localparam logic [7:0] C_DEF  = 8'b11010110;
    localparam logic [7:0] C_LU   = 8'b00011110;
    localparam logic [7:0] C_BR   = 8'b11111110;
    localparam logic [7:0] C_FRZ  = 8'b00000011;
    localparam logic [7:0] C_DRN  = 8'b01110110;
    localparam logic [7:0] C_DBR  = 8'b11111110;
    localparam logic [7:0] C_DLU  = 8'b01111110;
    localparam logic [7:0] C_OFF  = 8'b00000000;

    logic clk, rst;
    logic [4:0] id_rn, id_rm, ex_rd;
    logic id_uses_rm, ex_memread, ex_br_taken, mem_req, mem_ready, halt_req;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble;
    logic halted, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: mode 0=running, 1=draining, 2=halted
    int m_mode, m_left, m_wait, m_stall, m_flush;
    bit m_to;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rn(id_rn), .id_rm(id_rm), .id_uses_rm(id_uses_rm),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
        .idex_bubble(idex_bubble), .exmem_en(exmem_en), .memwb_en(memwb_en),
        .memwb_bubble(memwb_bubble), .halted(halted), .mem_timeout(mem_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0] rn, rm;
        logic       urm, mrd;
        logic [4:0] rd;
        logic       br, mreq, mrdy;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ctl_now();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_bubble, exmem_en, memwb_en, memwb_bubble};
    endfunction

    function automatic bit hazard();
        return ex_memread && ex_rd != 5'd31 &&
               (ex_rd == id_rn || (id_uses_rm && ex_rd == id_rm));
    endfunction

    function automatic int sat(input int v);
        return (v > MAXC) ? MAXC : v;
    endfunction

    function automatic logic [7:0] model_ctl();
        if (rst || m_mode == 2) return C_OFF;
        if (mem_req && !mem_ready) return C_FRZ;
        if (m_mode == 0) begin
            if (ex_br_taken) return C_BR;
            if (hazard()) return C_LU;
            return C_DEF;
        end
        if (ex_br_taken) return C_DBR;
        if (hazard()) return C_DLU;
        return C_DRN;
    endfunction

    task automatic model_update();
        bit frz;
        if (rst) begin
            m_mode = 0; m_left = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
            return;
        end
        frz = (m_mode != 2) && mem_req && !mem_ready;
        if (frz) m_stall++;
        else if (m_mode == 0 && ex_br_taken) m_flush++;
        else if (m_mode == 0 && hazard()) m_stall++;
        else if (m_mode == 1 && ex_br_taken) m_flush++;
        if (frz) begin
            m_wait++;
            if (m_wait >= MAX_WAIT) m_to = 1;
        end else begin
            m_wait = 0;
        end
        case (m_mode)
            0: if (halt_req && !frz) begin m_mode = 1; m_left = DRAIN_CYCLES; end
            1: begin
                if (!halt_req) m_mode = 0;
                else if (!frz) begin
                    m_left--;
                    if (m_left == 0) m_mode = 2;
                end
            end
            default: if (!halt_req) m_mode = 0;
        endcase
    endtask

    // Called at posedge+1 with inputs already applied; returns at next posedge+1.
    task automatic step();
        #3;
        check("ctl", {24'd0, ctl_now()}, {24'd0, model_ctl()});
        check("halted", {31'd0, halted}, {31'd0, (m_mode == 2) && !rst});
        check("mem_timeout", {31'd0, mem_timeout}, {31'd0, m_to && !rst});
        check("stall_cnt", 32'(stall_cnt), 32'(sat(m_stall)));
        check("flush_cnt", 32'(flush_cnt), 32'(sat(m_flush)));
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic cyc_chk(input string name, input logic [7:0] exp);
        #2;
        check(name, {24'd0, ctl_now()}, {24'd0, exp});
        step();
    endtask

    task automatic idle();
        id_rn = 5'd0; id_rm = 5'd0; id_uses_rm = 1'b0; ex_memread = 1'b0; ex_rd = 5'd0;
        ex_br_taken = 1'b0; mem_req = 1'b0; mem_ready = 1'b1; halt_req = 1'b0;
    endtask

    task automatic set_lu();
        ex_memread = 1'b1; ex_rd = 5'd3; id_rn = 5'd3;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        tbl[0] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 1'b1, C_DEF};
        tbl[1] = '{5'd3,  5'd0,  1'b0, 1'b1, 5'd3,  1'b0, 1'b0, 1'b1, C_LU};
        tbl[2] = '{5'd31, 5'd31, 1'b1, 1'b1, 5'd31, 1'b0, 1'b0, 1'b1, C_DEF};
        tbl[3] = '{5'd1,  5'd7,  1'b1, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, C_LU};
        tbl[4] = '{5'd1,  5'd7,  1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 1'b1, C_DEF};
        tbl[5] = '{5'd9,  5'd0,  1'b0, 1'b0, 5'd9,  1'b0, 1'b0, 1'b1, C_DEF};
        tbl[6] = '{5'd4,  5'd0,  1'b0, 1'b1, 5'd4,  1'b1, 1'b0, 1'b1, C_BR};
        tbl[7] = '{5'd4,  5'd0,  1'b0, 1'b1, 5'd4,  1'b1, 1'b1, 1'b0, C_FRZ};
        tbl[8] = '{5'd2,  5'd5,  1'b0, 1'b0, 5'd6,  1'b0, 1'b1, 1'b1, C_DEF};
        tbl[9] = '{5'd2,  5'd5,  1'b0, 1'b0, 5'd6,  1'b0, 1'b0, 1'b0, C_DEF};

        idle();
        rst = 1'b1;
        m_mode = 0; m_left = 0; m_wait = 0; m_stall = 0; m_flush = 0; m_to = 0;
        @(posedge clk);
        model_update();
        #1;

        cyc_chk("reset_ctl", C_OFF);
        rst = 1'b0;
        cyc_chk("first_run", C_DEF);

        for (int i = 0; i < 10; i++) begin
            idle();
            id_rn = tbl[i].rn; id_rm = tbl[i].rm; id_uses_rm = tbl[i].urm;
            ex_memread = tbl[i].mrd; ex_rd = tbl[i].rd; ex_br_taken = tbl[i].br;
            mem_req = tbl[i].mreq; mem_ready = tbl[i].mrdy;
            cyc_chk($sformatf("vec%0d", i), tbl[i].exp);
        end

        // Load-use stall then XZR destination
        do_reset();
        set_lu();
        cyc_chk("lu_ctl", C_LU);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        idle();
        ex_memread = 1'b1; ex_rd = 5'd31; id_rn = 5'd31;
        cyc_chk("xzr_ctl", C_DEF);
        check("xzr_stall_cnt", 32'(stall_cnt), 32'd1);

        // Branch wins over load-use
        do_reset();
        set_lu();
        ex_br_taken = 1'b1;
        cyc_chk("br_lu_ctl", C_BR);
        check("br_flush_cnt", 32'(flush_cnt), 32'd1);
        check("br_stall_cnt", 32'(stall_cnt), 32'd0);

        // Three-cycle memory wait
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc_chk("wait_ctl", C_FRZ);
        mem_ready = 1'b1;
        cyc_chk("wait_done_ctl", C_DEF);
        check("wait_stall_cnt", 32'(stall_cnt), 32'd3);

        // Timeout after MAX_WAIT frozen cycles, sticky until reset
        do_reset();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc_chk("to_ctl", C_FRZ);
            if (i == MAX_WAIT - 2) check("to_before", {31'd0, mem_timeout}, 32'd0);
            if (i == MAX_WAIT - 1) check("to_after", {31'd0, mem_timeout}, 32'd1);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        check("to_sticky", {31'd0, mem_timeout}, 32'd1);
        do_reset();
        check("to_cleared", {31'd0, mem_timeout}, 32'd0);

        // Plain drain and halt, then release
        do_reset();
        halt_req = 1'b1;
        cyc_chk("halt_run_cycle", C_DEF);
        for (int i = 0; i < DRAIN_CYCLES; i++) cyc_chk("drain_ctl", C_DRN);
        check("halted_set", {31'd0, halted}, 32'd1);
        cyc_chk("halted_ctl", C_OFF);
        halt_req = 1'b0;
        cyc_chk("halt_release_ctl", C_OFF);
        check("halted_clear", {31'd0, halted}, 32'd0);
        cyc_chk("resume_ctl", C_DEF);

        // Freeze mid-drain stretches DRAIN to six cycles
        do_reset();
        halt_req = 1'b1;
        cyc_chk("halt2_run_cycle", C_DEF);
        cyc_chk("drain2_a", C_DRN);
        cyc_chk("drain2_b", C_DRN);
        mem_req = 1'b1; mem_ready = 1'b0;
        cyc_chk("drain2_frz_a", C_FRZ);
        cyc_chk("drain2_frz_b", C_FRZ);
        mem_req = 1'b0; mem_ready = 1'b1;
        cyc_chk("drain2_c", C_DRN);
        check("drain2_not_halted", {31'd0, halted}, 32'd0);
        cyc_chk("drain2_d", C_DRN);
        check("drain2_halted", {31'd0, halted}, 32'd1);

        // Reset while frozen in DRAIN with counters non-zero
        do_reset();
        set_lu();
        for (int i = 0; i < 5; i++) step();
        check("mid_stall5", 32'(stall_cnt), 32'd5);
        idle();
        halt_req = 1'b1;
        step();
        mem_req = 1'b1; mem_ready = 1'b0;
        rst = 1'b1;
        cyc_chk("mid_rst_ctl", C_OFF);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_halted", {31'd0, halted}, 32'd0);
        rst = 1'b0;
        idle();
        cyc_chk("mid_rst_run", C_DEF);

        // Random run against the model
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            id_rn = pick_reg(); id_rm = pick_reg(); ex_rd = pick_reg();
            id_uses_rm  = 1'($urandom_range(0, 1));
            ex_memread  = 1'($urandom_range(0, 1));
            ex_br_taken = ($urandom_range(0, 4) == 0);
            mem_req     = ($urandom_range(0, 2) == 0);
            mem_ready   = ($urandom_range(0, 2) != 0);
            if (cyc >= 100 && (cyc % 150) < 18) begin
                mem_req = 1'b1; mem_ready = 1'b0;
            end
            if ($urandom_range(0, 11) == 0) halt_req = ~halt_req;
            rst = ($urandom_range(0, 79) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
